// File: rtl/mac_rr_scheduler.sv
// Round-robin scheduled multiply-accumulate unit: res = A*B+C per served requester.
// Define MAC_SCHED_PRIO0_EN to give requester 0 absolute priority over the rotation.
module mac_rr_scheduler #(
  parameter int DATA_WIDTH = 8,
  parameter int N_REQ      = 4,
  localparam int IDW       = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_b,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_c,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [DATA_WIDTH-1:0]       res_data,
  output logic [IDW-1:0]              res_id
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COMPUTE = 2'd1;
  localparam logic [1:0] HOLD    = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [IDW-1:0]        ptr_q, ptr_d;
  logic [IDW-1:0]        gid_q, gid_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [DATA_WIDTH-1:0] c_q, c_d;
  logic                  vld_q, vld_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [IDW-1:0]        id_q, id_d;

  logic [IDW-1:0]        gnt_idx;
  logic                  gnt_any;
  logic                  accept;
  int unsigned           rr_idx;

  logic [DATA_WIDTH-1:0] mac_hi_unused;
  logic [DATA_WIDTH-1:0] mac_lo;

  // Rotating search from the pointer; first valid requester wins.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    rr_idx  = 0;
    for (int k = 0; k < N_REQ; k++) begin
      rr_idx = (int'(ptr_q) + k) % N_REQ;
      if (!gnt_any && req_valid[rr_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = IDW'(rr_idx);
      end
    end
`ifdef MAC_SCHED_PRIO0_EN
    if (req_valid[0]) begin
      gnt_any = 1'b1;
      gnt_idx = '0;
    end
`endif
  end

  assign accept = rst_n && (state_q == IDLE) && gnt_any;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gnt_idx] = 1'b1;
  end

  // Full-width product; only the low DATA_WIDTH bits are kept.
  assign {mac_hi_unused, mac_lo} =
    {{DATA_WIDTH{1'b0}}, a_q} * {{DATA_WIDTH{1'b0}}, b_q} +
    {{DATA_WIDTH{1'b0}}, c_q};

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    vld_d   = vld_q;
    data_d  = data_q;
    id_d    = id_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          a_d     = req_a[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
          b_d     = req_b[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
          c_d     = req_c[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
          gid_d   = gnt_idx;
          state_d = COMPUTE;
`ifdef MAC_SCHED_PRIO0_EN
          if (gnt_idx != '0)
`endif
            ptr_d = (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + 1'b1;
        end
      end
      COMPUTE: begin
        data_d  = mac_lo;
        id_d    = gid_q;
        vld_d   = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (res_ready) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gid_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      vld_q   <= 1'b0;
      data_q  <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
      id_q    <= id_d;
    end
  end

  assign res_valid = vld_q;
  assign res_data  = data_q;
  assign res_id    = id_q;

endmodule
